// File: rtl/user_tree_pkg.sv
// Shared tree types: identifiers, node records and the path_node record consumed by tree_path_emitter.
// Optional build macro used by the path logic: TREE_PATH_CHECK_EN (depth legality check).
package user_tree_pkg;

    localparam int TREE_MAX_DEPTH = 8;
    localparam int ID_W           = 16;

    typedef logic [ID_W-1:0] identifier;
    typedef logic [$clog2(TREE_MAX_DEPTH):0] tree_depth;

    typedef struct packed {
        identifier field_id;
        logic [7:0] child_count;
        logic       is_leaf;
    } node_data;

    // A node as seen in a depth-first stream: its own ID and how deep it sits.
    typedef struct packed {
        identifier field_id;
        tree_depth depth;
    } path_node;

endpackage

// File: rtl/tree_path_stack.sv
// Per-depth field-ID stack: one write port, one async read port, plus the fill count of valid entries.
// The fill counter exists only when TREE_PATH_CHECK_EN is defined.
module tree_path_stack
    import user_tree_pkg::*;
#(
    parameter int MAX_DEPTH = TREE_MAX_DEPTH
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         wr_en,
    input  logic [$clog2(MAX_DEPTH)-1:0] wr_addr,
    input  identifier                    wr_data,
    input  logic [$clog2(MAX_DEPTH)-1:0] rd_addr,
    output identifier                    rd_data
`ifdef TREE_PATH_CHECK_EN
    ,
    output logic [$clog2(MAX_DEPTH):0]   fill
`endif
);

    localparam int AW = $clog2(MAX_DEPTH);

    identifier mem [MAX_DEPTH];

    // Entries are never reset; only slots below fill are ever read back.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

`ifdef TREE_PATH_CHECK_EN
    localparam logic [AW:0] FILL_ONE = 1;

    // Writing depth d leaves exactly d+1 valid entries: deeper ones are cut off.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fill <= '0;
        end else if (wr_en) begin
            fill <= {1'b0, wr_addr} + FILL_ONE;
        end
    end
`endif

endmodule

// File: rtl/tree_path_emitter.sv
// Turns a depth-first node stream back into root-to-node field-ID paths, one ID per beat.
// Build macro TREE_PATH_CHECK_EN enables the depth legality check and the path_err pulse.
module tree_path_emitter
    import user_tree_pkg::*;
#(
    parameter int MAX_DEPTH = TREE_MAX_DEPTH
) (
    input  logic      clk_i,
    input  logic      reset_i,
    input  path_node  node,
    input  logic      node_valid,
    output logic      node_rdy,
    output identifier field_id_o,
    output logic      field_id_valid,
    input  logic      field_id_rdy,
    output logic      field_id_last,
    output logic      path_err
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // once field_id_valid rises it stays high with stable data until field_id_rdy takes the beat.

    localparam int AW = $clog2(MAX_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    localparam logic [CW-1:0] IDX_ONE = 1;

    logic [0:0]    state;
    logic [CW-1:0] idx;
    logic [CW-1:0] tgt;
    logic [CW-1:0] node_d;
    logic          accept;
    logic          wr_en;
    logic          at_last;
    identifier     rd_data;

    assign accept = (state == ST_IDLE) && node_valid;

`ifdef TREE_PATH_CHECK_EN
    logic [CW-1:0] fill;
    logic [31:0]   depth_wide;
    logic          node_legal;

    // Compare at full width so an oversized depth can never alias to a legal one.
    assign depth_wide = 32'(node.depth);
    assign node_d     = CW'(node.depth);
    assign node_legal = (depth_wide <= 32'(fill)) && (depth_wide < 32'(MAX_DEPTH));
    assign wr_en      = accept && node_legal;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            path_err <= 1'b0;
        end else begin
            path_err <= accept && !node_legal;
        end
    end
`else
    assign node_d   = CW'(32'(node.depth) % 32'(MAX_DEPTH));
    assign wr_en    = accept;
    assign path_err = 1'b0;
`endif

    tree_path_stack #(
        .MAX_DEPTH (MAX_DEPTH)
    ) u_stack (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .wr_en   (wr_en),
        .wr_addr (node_d[AW-1:0]),
        .wr_data (node.field_id),
        .rd_addr (idx[AW-1:0]),
        .rd_data (rd_data)
`ifdef TREE_PATH_CHECK_EN
        ,
        .fill    (fill)
`endif
    );

    assign at_last = (idx == tgt);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= ST_IDLE;
            idx   <= '0;
            tgt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr_en) begin
                        tgt   <= node_d;
                        idx   <= '0;
                        state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (field_id_rdy) begin
                        if (at_last) begin
                            state <= ST_IDLE;
                        end else begin
                            idx <= idx + IDX_ONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // All outputs decode from registered state only; nothing depends on field_id_rdy.
    assign node_rdy       = (state == ST_IDLE);
    assign field_id_valid = (state == ST_EMIT);
    assign field_id_last  = field_id_valid && at_last;
    assign field_id_o     = field_id_valid ? rd_data : '0;

endmodule

// File: tb/tb_tree_path_emitter.sv
// Bench for tree_path_emitter: directed path cases, backpressure, mid-path reset, then random streams.
module tb_tree_path_emitter;
    import user_tree_pkg::*;

    localparam int MAX_DEPTH = TREE_MAX_DEPTH;
    localparam int W         = ID_W + 1;

    logic      clk = 1'b0;
    logic      reset_i;
    path_node  node;
    logic      node_valid;
    logic      node_rdy;
    identifier field_id_o;
    logic      field_id_valid;
    logic      field_id_rdy;
    logic      field_id_last;
    logic      path_err;

    tree_path_emitter #(.MAX_DEPTH(MAX_DEPTH)) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .node           (node),
        .node_valid     (node_valid),
        .node_rdy       (node_rdy),
        .field_id_o     (field_id_o),
        .field_id_valid (field_id_valid),
        .field_id_rdy   (field_id_rdy),
        .field_id_last  (field_id_last),
        .path_err       (path_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int            n_cmp    = 0;
    int            n_err    = 0;
    int            err_exp  = 0;
    int            err_seen = 0;
    logic          rdy_rand = 1'b0;
    logic [W-1:0]  exp_q[$];
    identifier     path_m[$];
    logic          mon_stall = 1'b0;
    logic [W-1:0]  mon_prev  = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the path is a list of IDs from the root; a node at depth d keeps the first d, appends itself.
    function automatic logic model_accept(input identifier id, input int d_raw);
        int   d;
        logic legal;
`ifdef TREE_PATH_CHECK_EN
        d     = d_raw;
        legal = (d <= path_m.size()) && (d < MAX_DEPTH);
`else
        d     = d_raw % MAX_DEPTH;
        legal = 1'b1;
`endif
        if (legal) begin
            while (path_m.size() > d) void'(path_m.pop_back());
            path_m.push_back(id);
            foreach (path_m[i]) exp_q.push_back({(i == d), path_m[i]});
        end else begin
            err_exp++;
        end
        return legal;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset_i) begin
                mon_stall = 1'b0;
            end else begin
                if (mon_stall) begin
                    check_eq("hold_valid", 32'(field_id_valid), 32'd1);
                    check_eq("hold_beat", 32'({field_id_last, field_id_o}), 32'(mon_prev));
                end
                if (field_id_valid && field_id_rdy) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL extra_beat: got id 0x%0h last %0b, expected no beat at %0t",
                                 field_id_o, field_id_last, $time);
                    end else begin
                        check_eq("beat", 32'({field_id_last, field_id_o}), 32'(exp_q.pop_front()));
                    end
                end
                if (path_err) err_seen++;
                mon_stall = field_id_valid && !field_id_rdy;
                mon_prev  = {field_id_last, field_id_o};
            end
        end
    end

    // ---------------- random downstream ready ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rdy_rand) field_id_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks (entered and left just after a falling edge) ----------------
    task automatic send_node(input identifier id, input int d, output logic legal);
        int waited;
        waited          = 0;
        node.field_id   = id;
        node.depth      = tree_depth'(d);
        node_valid      = 1'b1;
        while (!node_rdy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check_eq("accept_in_time", 32'(node_rdy), 32'd1);
        legal = model_accept(id, d);
        @(negedge clk);
        node_valid = 1'b0;
        check_eq("first_beat_latency", 32'(field_id_valid), 32'(legal));
        check_eq("err_timing", 32'(path_err), 32'(!legal));
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (!node_rdy && cycles < 1000) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_node(input identifier id, input int d);
        logic legal;
        int   busy;
        send_node(id, d, legal);
        wait_idle(busy);
        check_eq("busy_cycles", 32'(busy), legal ? 32'((d % MAX_DEPTH) + 1) : 32'd0);
        check_eq("drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        #1 reset_i = 1'b1;
        #1;
        check_eq("rst_valid", 32'(field_id_valid), 32'd0);
        check_eq("rst_rdy", 32'(node_rdy), 32'd1);
        check_eq("rst_last", 32'(field_id_last), 32'd0);
        check_eq("rst_err", 32'(path_err), 32'd0);
        check_eq("rst_id", 32'(field_id_o), 32'd0);
        @(negedge clk);
        exp_q.delete();
        path_m.delete();
        reset_i = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d beats still expected", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic legal;
        int   busy;
        int   sz;
        int   lim;
        int   d;
        identifier id;

        reset_i      = 1'b1;
        node         = '0;
        node_valid   = 1'b0;
        field_id_rdy = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("init_rdy", 32'(node_rdy), 32'd1);
        check_eq("init_valid", 32'(field_id_valid), 32'd0);
        check_eq("init_last", 32'(field_id_last), 32'd0);
        check_eq("init_err", 32'(path_err), 32'd0);
        check_eq("init_id", 32'(field_id_o), 32'd0);
        reset_i = 1'b0;
        @(negedge clk);

        // Growing, truncating and re-extending paths.
        run_node(16'd1, 0);
        run_node(16'd1, 0);
        run_node(16'd4, 1);
        run_node(16'd7, 2);
        run_node(16'd9, 1);
        run_node(16'd5, 2);

`ifdef TREE_PATH_CHECK_EN
        pulse_reset();
        run_node(16'd3, 2);
        run_node(16'd2, 0);
        run_node(16'd8, 2);
        run_node(16'd8, 1);
        run_node(16'd13, MAX_DEPTH + 1);
`else
        pulse_reset();
        run_node(16'd2, 0);
        run_node(16'd11, MAX_DEPTH + 1);
        run_node(16'd12, MAX_DEPTH);
`endif

        // Backpressure on the second beat of a depth-2 path.
        run_node(16'd10, 0);
        run_node(16'd20, 1);
        send_node(16'd30, 2, legal);
        @(negedge clk);
        field_id_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("bp_hold_id", 32'(field_id_o), 32'd20);
        check_eq("bp_hold_last", 32'(field_id_last), 32'd0);
        field_id_rdy = 1'b1;
        wait_idle(busy);
        check_eq("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a depth-3 path.
        run_node(16'd40, 0);
        run_node(16'd41, 1);
        run_node(16'd42, 2);
        send_node(16'd43, 3, legal);
        @(negedge clk);
        pulse_reset();
        run_node(16'd6, 0);

        // Random depth-first streams with random downstream stalls.
        rdy_rand = 1'b1;
        repeat (300) begin
            sz  = path_m.size();
            lim = (sz < MAX_DEPTH - 1) ? sz : MAX_DEPTH - 1;
            d   = int'($urandom_range(lim, 0));
`ifdef TREE_PATH_CHECK_EN
            if ($urandom_range(0, 4) == 0) d = int'($urandom_range(15, sz + 1));
`else
            if ($urandom_range(0, 3) == 0) d = d + MAX_DEPTH;
`endif
            id = 16'($urandom_range(0, 16'hffff));
            send_node(id, d, legal);
        end
        rdy_rand = 1'b0;
        field_id_rdy = 1'b1;
        wait_idle(busy);
        @(negedge clk);
        check_eq("rand_drained", 32'(exp_q.size()), 32'd0);
        check_eq("err_count", 32'(err_seen), 32'(err_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
